// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch path.
//   - fmt_e   : RISC-V format codes presented alongside each fetched word
//   - OP_*    : major opcode values (word[6:0]) used by the classifier
//   - state_e : fetch_sequencer FSM states
package fetch_pkg;

    typedef enum logic [2:0] {
        FMT_UNK = 3'd0,
        FMT_R   = 3'd1,
        FMT_I   = 3'd2,
        FMT_S   = 3'd3,
        FMT_SB  = 3'd4,
        FMT_U   = 3'd5,
        FMT_UJ  = 3'd6
    } fmt_e;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_PRESENT,
        S_ERR
    } state_e;

endpackage

// File: rtl/fmt_classify.sv
// fmt_classify: combinational RISC-V format decode from the major opcode.
//   word_i : 32-bit instruction word
//   fmt_o  : format code (fetch_pkg::fmt_e encoding); unknown opcodes map to FMT_UNK
module fmt_classify
    import fetch_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [2:0]  fmt_o
);

    always_comb begin
        fmt_o = FMT_UNK;
        case (word_i[6:0])
            OP_R:                      fmt_o = FMT_R;
            OP_LOAD, OP_IMM, OP_JALR:  fmt_o = FMT_I;
            OP_STORE:                  fmt_o = FMT_S;
            OP_BRANCH:                 fmt_o = FMT_SB;
            OP_LUI, OP_AUIPC:          fmt_o = FMT_U;
            OP_JAL:                    fmt_o = FMT_UJ;
            default:                   fmt_o = FMT_UNK;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches a run of consecutive words from instruction memory
// and presents each one, with its PC and format, over a valid/ready handshake.
//   clk_i, resetn_i          : clock, synchronous active-low reset
//   start_i/start_addr_i/count_i : run request (byte address, word count)
//   abort_i                  : cancel a run in progress
//   mem_addr_o/mem_read_o/mem_write_o/mem_rdata_i : memory master port
//                              (read data valid the cycle after mem_read_o)
//   ins_valid_o/ins_ready_i/ins_word_o/ins_pc_o/ins_fmt_o : consumer side
//   busy_o, done_o, err_o    : run status (done_o is a one-cycle pulse)
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 8,
    parameter int STRIDE = 4
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic [CNT_W-1:0]  count_i,
    input  logic              abort_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    input  logic [31:0]       mem_rdata_i,
    output logic              ins_valid_o,
    input  logic              ins_ready_i,
    output logic [31:0]       ins_word_o,
    output logic [ADDR_W-1:0] ins_pc_o,
    output logic [2:0]        ins_fmt_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q, pc_d, mem_addr_q, ins_pc_q;
    logic [CNT_W-1:0]  rem_q;
    logic [31:0]       ins_word_q;
    logic [2:0]        ins_fmt_q, fmt_w;
    logic              mem_read_q, ins_valid_q, busy_q, done_q, err_q;

    fmt_classify u_fmt (
        .word_i (mem_rdata_i),
        .fmt_o  (fmt_w)
    );

    // Wraps modulo 2^ADDR_W by construction.
    assign pc_d = pc_q + ADDR_W'(STRIDE);

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            rem_q       <= '0;
            mem_addr_q  <= '0;
            mem_read_q  <= 1'b0;
            ins_word_q  <= '0;
            ins_pc_q    <= '0;
            ins_fmt_q   <= '0;
            ins_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // Strobes default low; they are raised only on the transition
            // into the state that owns them.
            done_q     <= 1'b0;
            mem_read_q <= 1'b0;
            case (state_q)
                S_IDLE, S_ERR: begin
                    if (start_i) begin
                        if (start_addr_i[1:0] != 2'b00) begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end else if (count_i == '0) begin
                            state_q <= S_IDLE;
                            err_q   <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= S_ISSUE;
                            err_q      <= 1'b0;
                            busy_q     <= 1'b1;
                            pc_q       <= start_addr_i;
                            rem_q      <= count_i;
                            mem_read_q <= 1'b1;
                            mem_addr_q <= start_addr_i;
                        end
                    end
                end
                S_ISSUE: begin
                    if (abort_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (abort_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        ins_word_q  <= mem_rdata_i;
                        ins_pc_q    <= pc_q;
                        ins_fmt_q   <= fmt_w;
                        ins_valid_q <= 1'b1;
                        state_q     <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    // An accept that coincides with abort still consumes the word.
                    if (ins_ready_i) rem_q <= rem_q - CNT_W'(1);
                    if (abort_i) begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        ins_valid_q <= 1'b0;
                    end else if (ins_ready_i) begin
                        ins_valid_q <= 1'b0;
                        if (rem_q == CNT_W'(1)) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            pc_q       <= pc_d;
                            mem_addr_q <= pc_d;
                            mem_read_q <= 1'b1;
                            state_q    <= S_ISSUE;
                        end
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                    ins_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr_o  = mem_addr_q;
    assign mem_read_o  = mem_read_q;
    assign mem_write_o = 1'b0;
    assign ins_valid_o = ins_valid_q;
    assign ins_word_o  = ins_word_q;
    assign ins_pc_o    = ins_pc_q;
    assign ins_fmt_o   = ins_fmt_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized self-checking bench for fetch_sequencer.
// A run-level reference model predicts the PC sequence, the words and formats,
// the cycle each word becomes valid, and the done/busy/err status.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        resetn, start, abort, ins_ready;
    logic [31:0] start_addr;
    logic [7:0]  count;
    logic [31:0] mem_addr, mem_rdata, ins_word, ins_pc;
    logic        mem_read, mem_write, ins_valid, busy, done, err;
    logic [2:0]  ins_fmt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [logic [31:0]];
    logic [6:0]  opcs [12] = '{7'h33, 7'h03, 7'h13, 7'h67, 7'h23, 7'h63,
                               7'h37, 7'h17, 7'h6F, 7'h00, 7'h7F, 7'h0B};

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk_i        (clk),
        .resetn_i     (resetn),
        .start_i      (start),
        .start_addr_i (start_addr),
        .count_i      (count),
        .abort_i      (abort),
        .mem_addr_o   (mem_addr),
        .mem_read_o   (mem_read),
        .mem_write_o  (mem_write),
        .mem_rdata_i  (mem_rdata),
        .ins_valid_o  (ins_valid),
        .ins_ready_i  (ins_ready),
        .ins_word_o   (ins_word),
        .ins_pc_o     (ins_pc),
        .ins_fmt_o    (ins_fmt),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    // Memory: read data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_read) mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_fmt(input logic [31:0] w);
        logic [6:0] op;
        op = w[6:0];
        case (op)
            7'h33:               return 32'd1;
            7'h03, 7'h13, 7'h67: return 32'd2;
            7'h23:               return 32'd3;
            7'h63:               return 32'd4;
            7'h37, 7'h17:        return 32'd5;
            7'h6F:               return 32'd6;
            default:             return 32'd0;
        endcase
    endfunction

    task automatic preload(input logic [31:0] addr, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            logic [31:0] w;
            w = $urandom();
            w[6:0] = opcs[$urandom_range(0, 11)];
            mem[addr + 32'(4 * i)] = w;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_addr"},  mem_addr, 32'h0);
        check({tag, "_mem_read"},  32'(mem_read), 32'h0);
        check({tag, "_ins_word"},  ins_word, 32'h0);
        check({tag, "_ins_pc"},    ins_pc, 32'h0);
        check({tag, "_ins_fmt"},   32'(ins_fmt), 32'h0);
        check({tag, "_ins_valid"}, 32'(ins_valid), 32'h0);
        check({tag, "_busy"},      32'(busy), 32'h0);
        check({tag, "_done"},      32'(done), 32'h0);
        check({tag, "_err"},       32'(err), 32'h0);
        check({tag, "_mem_write"}, 32'(mem_write), 32'h0);
    endtask

    // One run from IDLE/ERR. abort_at = index of the word whose PRESENT gets
    // abort (-1: none); hold0 = cycles ready is withheld on the first word.
    task automatic do_run(input logic [31:0] addr, input int cnt, input int rdy_pct,
                          input int abort_at, input int hold0);
        logic [31:0] pcs [$];
        int  accepted, nxt_valid, held;
        bit  fin, exp_done, exp_valid, exp_read;
        for (int i = 0; i < cnt; i++) pcs.push_back(addr + 32'(4 * i));
        @(negedge clk);
        start = 1'b1; start_addr = addr; count = 8'(cnt);
        accepted = 0; nxt_valid = 2; held = 0; fin = 1'b0; exp_done = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            start = 1'b0; ins_ready = 1'b0; abort = 1'b0;
            exp_valid = !fin && (cyc >= nxt_valid);
            exp_read  = !fin && (cyc == nxt_valid - 2);
            check("mem_write", 32'(mem_write), 32'h0);
            check("done",      32'(done), 32'(exp_done));
            check("busy",      32'(busy), 32'(!fin));
            check("err",       32'(err), 32'h0);
            check("mem_read",  32'(mem_read), 32'(exp_read));
            check("ins_valid", 32'(ins_valid), 32'(exp_valid));
            if (fin) break;
            if (mem_read && exp_read) check("mem_addr", mem_addr, pcs[accepted]);
            if (ins_valid && exp_valid) begin
                check("ins_pc",   ins_pc, pcs[accepted]);
                check("ins_word", ins_word, mem[pcs[accepted]]);
                check("ins_fmt",  32'(ins_fmt), ref_fmt(mem[pcs[accepted]]));
            end
            if (exp_valid) begin
                ins_ready = ($urandom_range(1, 100) <= rdy_pct);
                if (accepted == 0 && held < hold0) begin
                    ins_ready = 1'b0;
                    held++;
                end
                if (accepted == abort_at) abort = 1'b1;
                if (ins_ready) accepted++;
                if (abort) begin
                    fin = 1'b1;
                end else if (ins_ready) begin
                    if (accepted == cnt) begin
                        fin = 1'b1;
                        exp_done = 1'b1;
                    end else begin
                        nxt_valid = cyc + 3;
                    end
                end
            end
            // A stray start while busy must be ignored.
            if (!fin && $urandom_range(0, 3) == 0) begin
                start = 1'b1; start_addr = $urandom(); count = 8'($urandom());
            end
        end
        if (!fin) check("run_timeout", 32'h0, 32'h1);
        start = 1'b0; ins_ready = 1'b0; abort = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("idle_done",      32'(done), 32'h0);
            check("idle_mem_read",  32'(mem_read), 32'h0);
            check("idle_ins_valid", 32'(ins_valid), 32'h0);
            check("idle_busy",      32'(busy), 32'h0);
        end
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; abort = 1'b0; ins_ready = 1'b0;
        start_addr = '0; count = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        resetn = 1'b1;

        // Basic run, ready tied high.
        preload(32'h28, 11);
        mem[32'h28] = 32'h00B50533;
        do_run(32'h28, 11, 100, -1, 0);

        // Backpressure on the first word.
        preload(32'h80, 2);
        do_run(32'h80, 2, 100, -1, 5);

        // count == 0: immediate done, no read.
        @(negedge clk);
        start = 1'b1; start_addr = 32'h100; count = 8'd0;
        @(negedge clk);
        start = 1'b0;
        check("cnt0_done", 32'(done), 32'h1);
        check("cnt0_read", 32'(mem_read), 32'h0);
        check("cnt0_busy", 32'(busy), 32'h0);
        @(negedge clk);
        check("cnt0_done_off", 32'(done), 32'h0);
        check("cnt0_read2",    32'(mem_read), 32'h0);

        // Misaligned start -> ERR; abort in ERR has no effect; retry clears it.
        start = 1'b1; start_addr = 32'h2A; count = 8'd3;
        @(negedge clk);
        start = 1'b0; abort = 1'b1;
        check("mis_err",  32'(err), 32'h1);
        check("mis_busy", 32'(busy), 32'h0);
        check("mis_read", 32'(mem_read), 32'h0);
        @(negedge clk);
        abort = 1'b0;
        check("mis_err_hold", 32'(err), 32'h1);
        check("mis_done",     32'(done), 32'h0);
        preload(32'h28, 1);
        do_run(32'h28, 1, 100, -1, 0);

        // Abort in PRESENT of the second word.
        preload(32'h200, 5);
        do_run(32'h200, 5, 100, 1, 0);

        // PC wrap-around.
        preload(32'hFFFF_FFFC, 2);
        do_run(32'hFFFF_FFFC, 2, 100, -1, 0);

        // Reset during WAIT.
        preload(32'h40, 3);
        @(negedge clk);
        start = 1'b1; start_addr = 32'h40; count = 8'd3;
        @(negedge clk);
        start = 1'b0;
        check("rst_issue_read", 32'(mem_read), 32'h1);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check_all_zero("rst_mid");
        resetn = 1'b1;
        do_run(32'h40, 3, 100, -1, 0);

        // Randomized runs.
        for (int r = 0; r < 25; r++) begin
            logic [31:0] a;
            int c, ab;
            a = {$urandom_range(0, 3) == 0 ? 16'hFFFF : 16'h0000, 16'($urandom())};
            a[1:0] = 2'b00;
            c  = $urandom_range(1, 6);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, c - 1) : -1;
            preload(a, c);
            do_run(a, c, $urandom_range(40, 100), ab, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controller that sequences the instruction memory (`mem`) for a run of N consecutive words.
- Sequence per word: drive address and read strobe, capture the returned word, classify its RISC-V format from the opcode.
- Presents each word to a downstream consumer (decoder/trace printer) over a valid/ready handshake.
- Sits between the run-control logic and the `mem` instance; it is the only master of the memory's address, read and write inputs.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- CNT_W, 8, width of the instruction-count input and the remaining counter.
- STRIDE, 4, byte increment between consecutive fetches.

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to begin a run; ignored unless in IDLE or ERR.
- start_addr  in  ADDR_W  byte address of the first word.
- count  in  CNT_W  number of words to fetch.
- abort  in  1  cancel the current run.
- mem_addr  out  ADDR_W  address to `mem`.
- mem_read  out  1  read strobe to `mem`.
- mem_write  out  1  write strobe to `mem`; constant 0.
- mem_rdata  in  32  `mem` output; valid the cycle after mem_read.
- ins_valid  out  1  presented word valid.
- ins_ready  in  1  consumer accepts the word.
- ins_word  out  32  fetched word.
- ins_pc  out  ADDR_W  address of ins_word.
- ins_fmt  out  3  format code from the package.
- busy  out  1  high in ISSUE, WAIT, PRESENT.
- done  out  1  one-cycle pulse when a run completes.
- err  out  1  high while in ERR.

Behaviour:
- Reset (resetn=0 at a rising edge), from any state: state=IDLE; outputs go to zero: mem_addr, ins_word, ins_pc, ins_fmt, ins_valid, mem_read, busy, done, err. mem_write is always 0. Internal pc and remaining counter are also cleared.
- IDLE:
  - start & start_addr[1:0]!=0 -> ERR.
  - else start & count==0 -> IDLE, with done=1 for one cycle.
  - else start -> ISSUE; pc<=start_addr, remaining<=count.
- ISSUE: mem_read=1, mem_addr=pc for exactly this cycle -> WAIT.
- WAIT:
  - Register ins_word<=mem_rdata, ins_pc<=pc, ins_fmt<=classify(mem_rdata).
  - ins_valid rises at the next edge -> PRESENT.
- PRESENT:
  - ins_valid=1; ins_word, ins_pc and ins_fmt are held stable until accepted.
  - On ins_ready: remaining<=remaining-1 and ins_valid drops next cycle.
  - If remaining==1 -> IDLE with done pulse; else pc<=pc+STRIDE -> ISSUE.
  - Without ins_ready, stay in PRESENT indefinitely.
- Throughput: 3 cycles per word with ins_ready tied high. First ins_valid appears 3 cycles after the start cycle.
- mem_read is low in every state other than ISSUE. mem_addr holds its last value outside ISSUE.
- PC arithmetic: modulo 2^ADDR_W; 0xFFFFFFFC+4 wraps to 0x00000000 with no error.
- abort:
  - Has priority over every transition except reset.
  - In any busy state it forces IDLE at the next edge: ins_valid=0, no done pulse, no err.
  - In IDLE or ERR it has no effect.
  - If abort and ins_ready coincide in PRESENT, the word is counted as accepted but the run still ends with no done pulse.
- ERR: err=1 held. A new start is evaluated exactly as in IDLE (retry allowed). resetn also clears it.
- start while busy is ignored.
- Format classification (combinational, on opcode = word[6:0]):
  - 0x33 -> R.
  - 0x03, 0x13, 0x67 -> I.
  - 0x23 -> S.
  - 0x63 -> SB.
  - 0x37, 0x17 -> U.
  - 0x6F -> UJ.
  - anything else -> UNK. UNK words are still presented.

Decomposition:
- Package fetch_pkg:
  - Format codes: UNK=0, R=1, I=2, S=3, SB=4, U=5, UJ=6.
  - Opcode constants (OP_R=0x33, OP_LOAD=0x03, OP_IMM=0x13, OP_JALR=0x67, OP_STORE=0x23, OP_BRANCH=0x63, OP_LUI=0x37, OP_AUIPC=0x17, OP_JAL=0x6F).
  - State enum: IDLE, ISSUE, WAIT, PRESENT, ERR.
- One combinational sub-module, fmt_classify: 32-bit word in, 3-bit format code out. It is reused by later decode stages.

Test Plan:
- Basic run: start_addr=0x28, count=11, ins_ready=1, memory preloaded -> 11 handshakes.
  - ins_pc = 0x28, 0x2C … 0x50; one word every 3 cycles.
  - Each ins_fmt matches the opcode (e.g. 0x00B50533 -> R).
  - done pulses once after the 11th acceptance; mem_write never 1.
- Backpressure: count=2, ins_ready held low for 5 cycles on the first word.
  - ins_valid stays 1 with ins_word/ins_pc stable.
  - No second mem_read until acceptance; done after the second acceptance.
- Boundaries:
  - count=0 -> done pulse the next cycle; mem_read never asserted.
  - start_addr=0x2A -> err=1, busy=0.
  - A subsequent start with 0x28, count=1 -> err clears and one word is presented.
- Abort mid-run: count=5, abort asserted in PRESENT of word 2 -> IDLE next cycle; ins_valid=0; no done; no further mem_read.
- Wrap-around: start_addr=0xFFFFFFFC, count=2 -> ins_pc 0xFFFFFFFC then 0x00000000; done pulses.
- Reset mid-run: resetn=0 during WAIT -> next edge all outputs zero, state IDLE. A start afterwards behaves as from power-up.
